// File: rtl/gate_sweep_ctrl_if.sv
// Handshake and gate-pin bundle between a bring-up controller, the gate under test and
// gate_sweep_ctrl. The master side owns start and the gate's Y output.
interface gate_sweep_ctrl_if;
  logic       start;
  logic       A;
  logic       B;
  logic       Y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] obs_table;
  logic [3:0] err_count;
  logic [1:0] vec_idx;

  modport master (
    output start, Y,
    input  A, B, busy, done, pass, obs_table, err_count, vec_idx
  );

  modport slave (
    input  start, Y,
    output A, B, busy, done, pass, obs_table, err_count, vec_idx
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for a 2-input gate: sweeps all four input vectors PASSES times,
// samples Y after a settle delay and reports the observed truth table and mismatch count.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = 4'b0111,
  parameter int unsigned PASSES        = 1
) (
  input logic              clk,
  input logic              rst,
  gate_sweep_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PassLast   = 4'(PASSES - 1);

  state_e     state_q;
  logic [7:0] settle_q;
  logic [3:0] pass_cnt_q;
  logic [1:0] vec_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] table_q;
  logic [3:0] err_q;

  logic       mismatch;
  logic [3:0] err_next;

  // Error count including the compare made on this edge, saturating at 15.
  always_comb begin
    mismatch = (bus.Y != EXPECTED[vec_q]);
    err_next = err_q;
    if (mismatch && (err_q != 4'd15)) begin
      err_next = err_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      settle_q   <= 8'd0;
      pass_cnt_q <= 4'd0;
      vec_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      table_q    <= 4'b0000;
      err_q      <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q    <= StRun;
            busy_q     <= 1'b1;
            table_q    <= 4'b0000;
            err_q      <= 4'd0;
            pass_q     <= 1'b0;
            settle_q   <= 8'd0;
            pass_cnt_q <= 4'd0;
            vec_q      <= 2'd0;
          end
        end
        StRun: begin
          if (settle_q == SettleLast) begin
            table_q[vec_q] <= bus.Y;
            err_q          <= err_next;
            settle_q       <= 8'd0;
            if (vec_q == 2'd3) begin
              vec_q <= 2'd0;
              if (pass_cnt_q == PassLast) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (err_next == 4'd0);
              end else begin
                pass_cnt_q <= pass_cnt_q + 4'd1;
              end
            end else begin
              vec_q <= vec_q + 2'd1;
            end
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A/B come straight from the registered vector index, so they are glitch-free.
  assign bus.A         = vec_q[1];
  assign bus.B         = vec_q[0];
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.obs_table = table_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: three instances with different settle/pass settings, each
// driving a truth-table gate model, checked against a run-level reference model.
module tb_gate_sweep_ctrl;

  localparam logic [3:0] Nand = 4'b0111;
  localparam logic [3:0] And  = 4'b1000;

  function automatic int unsigned s_of(int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic int unsigned p_of(int d);
    return (d == 1) ? 4 : 1;
  endfunction

  logic       clk;
  logic       rst;
  logic       start_v [3];
  logic [3:0] gate_fn [3];

  logic       a_w    [3];
  logic       b_w    [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic [1:0] vec_w  [3];
  logic [3:0] tbl_w  [3];
  logic [3:0] err_w  [3];

  int n_checks;
  int n_fail;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S = s_of(g);
    localparam int unsigned P = p_of(g);

    gate_sweep_ctrl_if ifc ();

    gate_sweep_ctrl #(
      .SETTLE_CYCLES(S),
      .EXPECTED     (Nand),
      .PASSES       (P)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
    );

    // Gate under test: truth table indexed by {A,B}.
    assign ifc.start = start_v[g];
    assign ifc.Y     = gate_fn[g][{ifc.A, ifc.B}];
    assign a_w[g]    = ifc.A;
    assign b_w[g]    = ifc.B;
    assign busy_w[g] = ifc.busy;
    assign done_w[g] = ifc.done;
    assign pass_w[g] = ifc.pass;
    assign vec_w[g]  = ifc.vec_idx;
    assign tbl_w[g]  = ifc.obs_table;
    assign err_w[g]  = ifc.err_count;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(int d, string when);
    check($sformatf("%s d%0d A", when, d), 32'(a_w[d]), 0);
    check($sformatf("%s d%0d B", when, d), 32'(b_w[d]), 0);
    check($sformatf("%s d%0d vec", when, d), 32'(vec_w[d]), 0);
    check($sformatf("%s d%0d busy", when, d), 32'(busy_w[d]), 0);
    check($sformatf("%s d%0d done", when, d), 32'(done_w[d]), 0);
    check($sformatf("%s d%0d pass", when, d), 32'(pass_w[d]), 0);
    check($sformatf("%s d%0d table", when, d), 32'(tbl_w[d]), 0);
    check($sformatf("%s d%0d err", when, d), 32'(err_w[d]), 0);
  endtask

  // Follows one run from the negedge after its start edge through the done cycle.
  task automatic follow(int d, logic [3:0] fn, bit drop_start);
    int unsigned s    = s_of(d);
    int unsigned p    = p_of(d);
    int unsigned len  = 4 * s * p;
    int unsigned mism = p * $countones(fn ^ Nand);
    int unsigned exp_err = (mism > 15) ? 15 : mism;
    logic [1:0]  v;
    for (int t = 0; t < int'(len); t++) begin
      @(negedge clk);
      v = 2'((t / int'(s)) % 4);
      check($sformatf("d%0d busy t%0d", d, t), 32'(busy_w[d]), 1);
      check($sformatf("d%0d done t%0d", d, t), 32'(done_w[d]), 0);
      check($sformatf("d%0d vec t%0d", d, t), 32'(vec_w[d]), 32'(v));
      check($sformatf("d%0d AB t%0d", d, t), 32'({a_w[d], b_w[d]}), 32'(v));
      if (t == 0) begin
        check($sformatf("d%0d table clr", d), 32'(tbl_w[d]), 0);
        check($sformatf("d%0d err clr", d), 32'(err_w[d]), 0);
        check($sformatf("d%0d pass clr", d), 32'(pass_w[d]), 0);
        if (drop_start) start_v[d] = 1'b0;
      end
    end
    @(negedge clk);
    check($sformatf("d%0d done", d), 32'(done_w[d]), 1);
    check($sformatf("d%0d busy end", d), 32'(busy_w[d]), 0);
    check($sformatf("d%0d vec end", d), 32'(vec_w[d]), 0);
    check($sformatf("d%0d AB end", d), 32'({a_w[d], b_w[d]}), 0);
    check($sformatf("d%0d table", d), 32'(tbl_w[d]), 32'(fn));
    check($sformatf("d%0d err", d), 32'(err_w[d]), exp_err);
    check($sformatf("d%0d pass", d), 32'(pass_w[d]), 32'(exp_err == 0));
  endtask

  task automatic run(int d, logic [3:0] fn, bit hold);
    gate_fn[d] = fn;
    start_v[d] = 1'b1;
    @(posedge clk);
    follow(d, fn, !hold);
  endtask

  initial begin
    int         d;
    logic [3:0] fn;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      gate_fn[i] = Nand;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset(i, "por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(0, Nand, 1'b0);
    run(0, 4'b0000, 1'b0);
    run(0, 4'b1111, 1'b0);
    run(1, And, 1'b0);
    run(2, Nand, 1'b0);

    // Results hold in IDLE.
    repeat (3) @(negedge clk);
    check("d2 hold table", 32'(tbl_w[2]), 32'(Nand));
    check("d2 hold pass", 32'(pass_w[2]), 1);
    check("d1 hold err", 32'(err_w[1]), 15);

    // Reset in the 3rd cycle of a run, after vector 0 has been sampled.
    gate_fn[0] = Nand;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check_reset(i, "midrun");
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check($sformatf("no done t%0d", t), 32'(done_w[0]), 0);
      check($sformatf("no busy t%0d", t), 32'(busy_w[0]), 0);
    end
    run(0, Nand, 1'b0);

    // start held high: ignored while busy, re-accepted in the done cycle.
    run(0, Nand, 1'b1);
    follow(0, Nand, 1'b1);

    for (int i = 0; i < 8; i++) begin
      d  = int'($urandom_range(0, 2));
      fn = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(d, fn, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
